if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined CPU: owns the program counter and the IF/ID pipeline register. It drives the instruction-memory address and captures the fetched word plus PC+4 into IF/ID for the decode stage. It consumes the hazard unit's load-use stall and the branch flush/redirect produced in EX. Flush has priority over stall.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset (word aligned)
- PC_STEP, 4, sequential PC increment in bytes
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- stall_i  input  1  load-use hazard from hazard unit; freeze PC and IF/ID
- flush_i  input  1  taken branch resolved; redirect PC, squash IF/ID
- branch_target_i  input  32  redirect address, sampled when flush_i=1
- instr_i  input  32  instruction memory read data for address pc_o (combinational)
- pc_o  output  32  current PC / instruction memory address
- ifid_pc4_o  output  32  registered PC+PC_STEP of the instruction in ID
- ifid_instr_o  output  32  registered instruction in ID (32'h0 = nop)
- ifid_valid_o  output  1  IF/ID holds a real instruction
- stall_cnt_o  output  16  stall-cycle count (IF_PERF_CNT_EN only, else 0)
- flush_cnt_o  output  16  flush-event count (IF_PERF_CNT_EN only, else 0)

## Operation
- State machine, 2 bits: BOOT, RUN, STALL.
- Reset (async, any time incl. mid-stall/mid-flush): state=BOOT, pc_o=PC_RESET, ifid_pc4_o=0, ifid_instr_o=0, ifid_valid_o=0, counters=0.
- BOOT: exactly one cycle after reset release; PC held, IF/ID stays invalid, stall_i/flush_i ignored; -> RUN.
- RUN / STALL, per edge, priority order:
  - flush_i=1: pc <= {branch_target_i[31:2],2'b00}; IF/ID <= nop (instr 0, pc4 0, valid 0); flush_cnt++; -> RUN.
  - else stall_i=1: pc, IF/ID held unchanged; stall_cnt++; -> STALL.
  - else: pc <= pc+PC_STEP; IF/ID <= {pc_o+PC_STEP, instr_i, valid 1}; -> RUN.
- STALL is behaviourally identical to RUN; it marks that the previous cycle was frozen (stall runs count once per cycle).
- Arithmetic: PC add is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. Branch target bits [1:0] are discarded.
- Simultaneous flush_i and stall_i: flush wins; the stall cycle is not counted.

## Timing
- pc_o is a register output; instruction memory is read combinationally in the same cycle.
- IF/ID latency: instruction at pc_o appears on ifid_instr_o one edge later.
- Redirect latency: flush_i high in cycle N -> pc_o=target and ifid_valid_o=0 in cycle N+1; target instruction in IF/ID in N+2.
- Stall held for k cycles freezes all outputs for k cycles; the next un-stalled edge resumes with no lost or duplicated instruction.
- First real instruction (PC_RESET) reaches IF/ID two edges after reset release (BOOT + one fetch).

## Configuration
- IF_PERF_CNT_EN defined: stall_cnt_o counts cycles where stall_i advanced the stall path; flush_cnt_o counts edges where flush_i was taken; both saturate at 16'hFFFF; cleared only by rst_i.
- Undefined: counter registers are not built; stall_cnt_o and flush_cnt_o are constant 16'h0. All other behaviour is identical.

## Test plan
- Reset release, no stall/flush, instr_i = {pc} -> pc_o 0,0,4,8,...; ifid_instr_o 0 then 32'h0 at valid, ifid_pc4_o 4, 8, 12...
- stall_i high 3 cycles at pc_o=8 -> pc_o stays 8, IF/ID holds pc4=8; resumes at 12; stall_cnt_o=3 (with macro).
- flush_i with branch_target_i=32'h0000_0103 at pc_o=16 -> next cycle pc_o=32'h100, ifid_valid_o=0, ifid_instr_o=0; flush_cnt_o=1.
- flush_i and stall_i both high -> redirect taken, IF/ID squashed, stall_cnt_o unchanged.
- PC_RESET=32'hFFFF_FFF8 -> pc_o FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_i asserted mid-stall asynchronously -> outputs return to reset values before next edge; BOOT repeats; macro undefined -> counters read 0 throughout.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter plus IF/ID pipeline register.
// Optional stall/flush performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_take_flush;
  logic        w_take_stall;
  logic        w_advance;
  logic [31:0] w_pc_seq;
  logic [31:0] w_pc_redirect;

  logic [31:0] r_pc;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;

  assign w_pc_seq      = r_pc + PC_STEP;
  assign w_pc_redirect = {branch_target_i[31:2], 2'b00};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= BOOT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      BOOT:       w_state_nxt = RUN;
      RUN, STALL: w_state_nxt = (!flush_i && stall_i) ? STALL : RUN;
      default:    w_state_nxt = BOOT;
    endcase
  end

  // BOOT ignores both hazard inputs; flush outranks stall everywhere else.
  always_comb begin
    w_take_flush = 1'b0;
    w_take_stall = 1'b0;
    w_advance    = 1'b0;
    if (r_state == RUN || r_state == STALL) begin
      w_take_flush = flush_i;
      w_take_stall = !flush_i && stall_i;
      w_advance    = !flush_i && !stall_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc         <= PC_RESET;
      r_ifid_pc4   <= '0;
      r_ifid_instr <= '0;
      r_ifid_valid <= 1'b0;
    end else if (w_take_flush) begin
      r_pc         <= w_pc_redirect;
      r_ifid_pc4   <= '0;
      r_ifid_instr <= '0;
      r_ifid_valid <= 1'b0;
    end else if (w_advance) begin
      r_pc         <= w_pc_seq;
      r_ifid_pc4   <= w_pc_seq;
      r_ifid_instr <= instr_i;
      r_ifid_valid <= 1'b1;
    end
  end

  assign pc_o         = r_pc;
  assign ifid_pc4_o   = r_ifid_pc4;
  assign ifid_instr_o = r_ifid_instr;
  assign ifid_valid_o = r_ifid_valid;

`ifdef IF_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_take_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_take_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  logic w_unused;
  assign w_unused    = w_take_stall;
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table through a scoreboard queue, plus
// async-reset-mid-stall and BOOT-ignores-hazards sequences; a second instance checks PC wrap.
module tb_if_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] branch_target_i;
  logic [31:0] instr_i, instr_w;
  logic [31:0] pc_o, ifid_pc4_o, ifid_instr_o;
  logic        ifid_valid_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;
  logic [31:0] pc_w, ifid_pc4_w, ifid_instr_w;
  logic        ifid_valid_w;
  logic [15:0] stall_cnt_w, flush_cnt_w;

  always #5 clk_i = ~clk_i;

  // Instruction memory model: word content derived from its address.
  assign instr_i = pc_o ^ 32'h0000_0013;
  assign instr_w = pc_w ^ 32'h0000_0013;

  if_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .branch_target_i(branch_target_i), .instr_i(instr_i), .pc_o(pc_o),
    .ifid_pc4_o(ifid_pc4_o), .ifid_instr_o(ifid_instr_o), .ifid_valid_o(ifid_valid_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  if_stage #(.PC_RESET(32'hFFFF_FFF8), .PC_STEP(32'd4)) dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .branch_target_i(branch_target_i), .instr_i(instr_w), .pc_o(pc_w),
    .ifid_pc4_o(ifid_pc4_w), .ifid_instr_o(ifid_instr_w), .ifid_valid_o(ifid_valid_w),
    .stall_cnt_o(stall_cnt_w), .flush_cnt_o(flush_cnt_w)
  );

  typedef struct {
    logic        s;
    logic        f;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        v;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [31:0] wpc;
  } vec_t;

  vec_t tbl[16];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [15:0] ecnt(input logic [15:0] x);
`ifdef IF_PERF_CNT_EN
    return x;
`else
    return (x & 16'h0000);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t e);
    chk({tag, " pc"},     pc_o,         e.pc);
    chk({tag, " pc4"},    ifid_pc4_o,   e.pc4);
    chk({tag, " instr"},  ifid_instr_o, e.instr);
    chk({tag, " valid"},  {31'd0, ifid_valid_o}, {31'd0, e.v});
    chk({tag, " scnt"},   {16'd0, stall_cnt_o},  {16'd0, ecnt(e.sc)});
    chk({tag, " fcnt"},   {16'd0, flush_cnt_o},  {16'd0, ecnt(e.fc)});
    chk({tag, " wrappc"}, pc_w,         e.wpc);
  endtask

  task automatic step(input string tag, input vec_t v);
    vec_t e;
    stall_i         = v.s;
    flush_i         = v.f;
    branch_target_i = v.tgt;
    sb.push_back(v);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    chk_vec(tag, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        s     f     tgt            pc             pc4            instr          v     sc     fc     wpc
    tbl[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,         32'h0,         32'h0,         1'b0, 16'd0, 16'd0, 32'hFFFF_FFF8};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,        32'h4,         32'h4,         32'h13,        1'b1, 16'd0, 16'd0, 32'hFFFF_FFFC};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,        32'h8,         32'h8,         32'h17,        1'b1, 16'd0, 16'd0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,        32'h8,         32'h8,         32'h17,        1'b1, 16'd1, 16'd0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,        32'h8,         32'h8,         32'h17,        1'b1, 16'd2, 16'd0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,        32'h8,         32'h8,         32'h17,        1'b1, 16'd3, 16'd0, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,        32'hC,         32'hC,         32'h1B,        1'b1, 16'd3, 16'd0, 32'h4};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,        32'h10,        32'h10,        32'h1F,        1'b1, 16'd3, 16'd0, 32'h8};
    tbl[8]  = '{1'b0, 1'b1, 32'h103,      32'h100,       32'h0,         32'h0,         1'b0, 16'd3, 16'd1, 32'h100};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,        32'h104,       32'h104,       32'h113,       1'b1, 16'd3, 16'd1, 32'h104};
    tbl[10] = '{1'b1, 1'b1, 32'h2002,     32'h2000,      32'h0,         32'h0,         1'b0, 16'd3, 16'd2, 32'h2000};
    tbl[11] = '{1'b1, 1'b0, 32'h0,        32'h2000,      32'h0,         32'h0,         1'b0, 16'd4, 16'd2, 32'h2000};
    tbl[12] = '{1'b0, 1'b0, 32'h0,        32'h2004,      32'h2004,      32'h2013,      1'b1, 16'd4, 16'd2, 32'h2004};
    tbl[13] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,        32'h0,         1'b0, 16'd4, 16'd3, 32'hFFFF_FFFC};
    tbl[14] = '{1'b0, 1'b0, 32'h0,        32'h0,         32'h0,         32'hFFFF_FFEF, 1'b1, 16'd4, 16'd3, 32'h0};
    tbl[15] = '{1'b0, 1'b0, 32'h0,        32'h4,         32'h4,         32'h13,        1'b1, 16'd4, 16'd3, 32'h4};

    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; branch_target_i = '0;
    #12;
    chk("rst pc",    pc_o,         32'h0);
    chk("rst pc4",   ifid_pc4_o,   32'h0);
    chk("rst instr", ifid_instr_o, 32'h0);
    chk("rst valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("rst wrappc", pc_w,        32'hFFFF_FFF8);
    rst_i = 1'b0;

    for (int unsigned i = 0; i < 16; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Async reset while stalled: outputs clear before any clock edge.
    stall_i = 1'b1; flush_i = 1'b0;
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst pc",    pc_o,         32'h0);
    chk("arst pc4",   ifid_pc4_o,   32'h0);
    chk("arst instr", ifid_instr_o, 32'h0);
    chk("arst valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("arst scnt",  {16'd0, stall_cnt_o}, 32'd0);
    chk("arst fcnt",  {16'd0, flush_cnt_o}, 32'd0);
    chk("arst wrappc", pc_w,        32'hFFFF_FFF8);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // BOOT cycle must ignore simultaneous flush and stall.
    step("boot", '{1'b1, 1'b1, 32'h500, 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0, 32'hFFFF_FFF8});
    step("post", '{1'b0, 1'b0, 32'h0,   32'h4, 32'h4, 32'h13, 1'b1, 16'd0, 16'd0, 32'hFFFF_FFFC});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
